// File: rtl/stream_output_selector.sv
// stream_output_selector
//   Picks one of NUM_CH processed pixel streams, or the bypass grey stream,
//   for the VGA pixel path. The slide-switch selection is synchronised,
//   debounced and decoded. It is then committed either on a frame boundary
//   (FRAME_SYNC=1) or as soon as it is pending (FRAME_SYNC=0).
//
// Ports
//   clk           pixel clock
//   rst           synchronous active-high reset
//   sel_sw        raw slide-switch bits (asynchronous to clk)
//   frame_start   single-cycle pulse at pixel (0,0)
//   ch_data       flattened channel pixels, channel k at [k*DW +: DW]
//   ch_valid      per-channel pixel valid
//   bypass_data   unprocessed grey pixel
//   bypass_valid  bypass pixel valid
//   out_data      selected pixel (registered, holds when not valid)
//   out_valid     selected valid (registered)
//   active_sel    committed selection: 0 = bypass, k+1 = channel k
//   sel_pending   debounced selection differs from active_sel
module stream_output_selector #(
    parameter int unsigned NUM_CH       = 9,
    parameter int unsigned DW           = 8,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned FRAME_SYNC   = 1,
    parameter int unsigned SW_INDEX_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        sel_sw,
    input  logic                     frame_start,
    input  logic [NUM_CH*DW-1:0]     ch_data,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [DW-1:0]            bypass_data,
    input  logic                     bypass_valid,
    output logic [DW-1:0]            out_data,
    output logic                     out_valid,
    output logic [SW_INDEX_W-1:0]    active_sel,
    output logic                     sel_pending
);

    localparam int unsigned         CNT_W      = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(DEBOUNCE_CYC);
    localparam bit                  COMMIT_ANY = (FRAME_SYNC == 0);

    logic [NUM_CH-1:0]      sync1_q, sync1_d;
    logic [NUM_CH-1:0]      sync2_q, sync2_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0]      deb_q, deb_d;
    logic [SW_INDEX_W-1:0]  active_sel_q, active_sel_d;
    logic                   sel_pending_q, sel_pending_d;
    logic [DW-1:0]          out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;

    logic [SW_INDEX_W-1:0]  dec_sel_c;
    logic [DW-1:0]          sel_data_c;
    logic                   sel_valid_c;

    // One-hot decode of the debounced switches; zero or multiple bits -> bypass.
    always_comb begin
        dec_sel_c = '0;
        if ((deb_q != '0) && ((deb_q & (deb_q - NUM_CH'(1))) == '0)) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (deb_q[k]) begin
                    dec_sel_c = SW_INDEX_W'(k + 1);
                end
            end
        end
    end

    // Source mux driven by the committed selection.
    always_comb begin
        sel_data_c  = bypass_data;
        sel_valid_c = bypass_valid;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (active_sel_q == SW_INDEX_W'(k + 1)) begin
                sel_data_c  = ch_data[k*DW +: DW];
                sel_valid_c = ch_valid[k];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        sync1_d       = sel_sw;
        sync2_d       = sync1_q;
        cnt_d         = cnt_q;
        deb_d         = deb_q;
        active_sel_d  = active_sel_q;
        sel_pending_d = sel_pending_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;

        // cnt counts the cycles sync2 has held its value; a change about to
        // land in sync2 zeroes it, so it reads 0 in the cycle sync2 changes.
        if (sync1_q != sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (cnt_d == CNT_MAX) begin
            deb_d = sync2_q;
        end

        sel_pending_d = (dec_sel_c != active_sel_q);

        // Registered pending means a debounce finishing alongside
        // frame_start waits for the following frame.
        if (sel_pending_q && (COMMIT_ANY || frame_start)) begin
            active_sel_d = dec_sel_c;
        end

        out_valid_d = sel_valid_c;
        if (sel_valid_c) begin
            out_data_d = sel_data_c;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            cnt_q         <= '0;
            deb_q         <= '0;
            active_sel_q  <= '0;
            sel_pending_q <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            cnt_q         <= cnt_d;
            deb_q         <= deb_d;
            active_sel_q  <= active_sel_d;
            sel_pending_q <= sel_pending_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign active_sel  = active_sel_q;
    assign sel_pending = sel_pending_q;

endmodule

// File: tb/tb_stream_output_selector.sv
// Directed bench for stream_output_selector. Instance u_fs commits on
// frame_start, u_nf commits as soon as a selection is pending. Both share
// every input. Cycle n is the interval after the n-th posedge, and inputs
// and outputs are both touched 1 time unit after that edge.
module tb_stream_output_selector;

    localparam int unsigned NUM_CH = 9;
    localparam int unsigned DW     = 8;
    localparam int unsigned SW_W   = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_CH-1:0]     sel_sw;
    logic                  frame_start;
    logic [NUM_CH*DW-1:0]  ch_data;
    logic [NUM_CH-1:0]     ch_valid;
    logic [DW-1:0]         bypass_data;
    logic                  bypass_valid;

    logic [DW-1:0]         fs_data,    nf_data;
    logic                  fs_valid,   nf_valid;
    logic [SW_W-1:0]       fs_active,  nf_active;
    logic                  fs_pending, nf_pending;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_output_selector #(
        .NUM_CH(NUM_CH), .DW(DW), .DEBOUNCE_CYC(4), .FRAME_SYNC(1), .SW_INDEX_W(SW_W)
    ) u_fs (
        .clk(clk), .rst(rst), .sel_sw(sel_sw), .frame_start(frame_start),
        .ch_data(ch_data), .ch_valid(ch_valid),
        .bypass_data(bypass_data), .bypass_valid(bypass_valid),
        .out_data(fs_data), .out_valid(fs_valid),
        .active_sel(fs_active), .sel_pending(fs_pending)
    );

    stream_output_selector #(
        .NUM_CH(NUM_CH), .DW(DW), .DEBOUNCE_CYC(4), .FRAME_SYNC(0), .SW_INDEX_W(SW_W)
    ) u_nf (
        .clk(clk), .rst(rst), .sel_sw(sel_sw), .frame_start(frame_start),
        .ch_data(ch_data), .ch_valid(ch_valid),
        .bypass_data(bypass_data), .bypass_valid(bypass_valid),
        .out_data(nf_data), .out_valid(nf_valid),
        .active_sel(nf_active), .sel_pending(nf_pending)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bypass_data = 8'h5A;
        bypass_valid = 1'b1;
        tick(2);
        n_checks++;
        if ({fs_data, fs_valid, fs_active, fs_pending} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_state: got data=%h valid=%b sel=%0d pend=%b want all zero",
                     fs_data, fs_valid, fs_active, fs_pending);
        end
        rst = 1'b0;
        tick(1);
        n_checks++;
        if (fs_data !== 8'h5A || fs_valid !== 1'b1 || fs_active !== 4'd0 || fs_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_after_reset: got data=%h valid=%b sel=%0d pend=%b want 5a 1 0 0",
                     fs_data, fs_valid, fs_active, fs_pending);
        end
        tick(8);
    endtask

    task automatic test_frame_commit;
        sel_sw = 9'h004;                       // cycle T
        tick(6);                               // T+6: debounced, pending not yet
        n_checks++;
        if (fs_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_early: got %b want 0", fs_pending);
        end
        tick(1);                               // T+7
        n_checks++;
        if (fs_pending !== 1'b1 || fs_active !== 4'd0) begin
            n_fail++;
            $display("FAIL pend_rise: got pend=%b sel=%0d want 1 0", fs_pending, fs_active);
        end
        tick(3);                               // T+10
        frame_start = 1'b1;
        tick(1);                               // T+11
        frame_start = 1'b0;
        n_checks++;
        if (fs_active !== 4'd3 || fs_pending !== 1'b1 || fs_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL commit: got sel=%0d pend=%b data=%h want 3 1 5a",
                     fs_active, fs_pending, fs_data);
        end
        tick(1);                               // T+12
        n_checks++;
        if (fs_data !== 8'h33 || fs_valid !== 1'b1 || fs_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL ch2_out: got data=%h valid=%b pend=%b want 33 1 0",
                     fs_data, fs_valid, fs_pending);
        end
    endtask

    task automatic test_bounce;
        sel_sw = 9'h010;                       // cycle B
        tick(1);
        sel_sw = 9'h004;                       // B+1
        tick(1);
        sel_sw = 9'h010;                       // B+2, held
        for (int i = 3; i <= 8; i++) begin
            tick(1);
            frame_start = (i == 4);
            n_checks++;
            if (fs_pending !== 1'b0 || fs_active !== 4'd3) begin
                n_fail++;
                $display("FAIL bounce_hold_%0d: got pend=%b sel=%0d want 0 3",
                         i, fs_pending, fs_active);
            end
        end
        tick(1);                               // B+9
        n_checks++;
        if (fs_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_pend: got %b want 1", fs_pending);
        end
        tick(3);                               // B+12
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(1);                               // B+14
        n_checks++;
        if (fs_active !== 4'd5 || fs_data !== 8'h35) begin
            n_fail++;
            $display("FAIL bounce_commit: got sel=%0d data=%h want 5 35", fs_active, fs_data);
        end
    endtask

    task automatic test_pending_cancel;
        sel_sw = 9'h004;                       // cycle C
        tick(7);
        n_checks++;
        if (fs_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL cancel_rise: got %b want 1", fs_pending);
        end
        sel_sw = 9'h010;                       // back to active value at C+7
        tick(6);                               // C+13
        n_checks++;
        if (fs_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL cancel_hold: got %b want 1", fs_pending);
        end
        tick(1);                               // C+14
        frame_start = 1'b1;
        n_checks++;
        if (fs_pending !== 1'b0 || fs_active !== 4'd5) begin
            n_fail++;
            $display("FAIL cancel_clear: got pend=%b sel=%0d want 0 5", fs_pending, fs_active);
        end
        tick(1);
        frame_start = 1'b0;
        tick(1);
        n_checks++;
        if (fs_active !== 4'd5 || fs_data !== 8'h35) begin
            n_fail++;
            $display("FAIL cancel_nocommit: got sel=%0d data=%h want 5 35", fs_active, fs_data);
        end
    endtask

    task automatic test_multi_bit;
        bypass_data = 8'hA5;
        sel_sw = 9'h006;
        tick(7);
        n_checks++;
        if (fs_pending !== 1'b1 || fs_active !== 4'd5) begin
            n_fail++;
            $display("FAIL multi_pend: got pend=%b sel=%0d want 1 5", fs_pending, fs_active);
        end
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        n_checks++;
        if (fs_active !== 4'd0) begin
            n_fail++;
            $display("FAIL multi_commit: got sel=%0d want 0", fs_active);
        end
        tick(1);
        n_checks++;
        if (fs_data !== 8'hA5 || fs_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_bypass: got data=%h valid=%b want a5 1", fs_data, fs_valid);
        end
    endtask

    task automatic test_no_frame_sync;
        rst = 1'b1;
        sel_sw = '0;
        tick(1);
        rst = 1'b0;
        ch_valid[8] = 1'b0;
        tick(8);
        sel_sw = 9'h100;                       // cycle t
        tick(7);                               // t+7
        n_checks++;
        if (nf_active !== 4'd0 || nf_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL nf_before: got sel=%0d pend=%b want 0 1", nf_active, nf_pending);
        end
        tick(1);                               // t+8
        n_checks++;
        if (nf_active !== 4'd9 || fs_active !== 4'd0) begin
            n_fail++;
            $display("FAIL nf_commit: got nf=%0d fs=%0d want 9 0", nf_active, fs_active);
        end
        ch_valid[8] = 1'b1;
        ch_data[8*DW +: DW] = 8'h39;
        tick(1);                               // t+9
        n_checks++;
        if (nf_valid !== 1'b1 || nf_data !== 8'h39) begin
            n_fail++;
            $display("FAIL nf_px0: got valid=%b data=%h want 1 39", nf_valid, nf_data);
        end
        ch_valid[8] = 1'b0;
        ch_data[8*DW +: DW] = 8'h77;
        tick(1);                               // t+10
        n_checks++;
        if (nf_valid !== 1'b0 || nf_data !== 8'h39) begin
            n_fail++;
            $display("FAIL nf_gap: got valid=%b data=%h want 0 39", nf_valid, nf_data);
        end
        ch_valid[8] = 1'b1;
        ch_data[8*DW +: DW] = 8'h4C;
        tick(1);                               // t+11
        n_checks++;
        if (nf_valid !== 1'b1 || nf_data !== 8'h4C) begin
            n_fail++;
            $display("FAIL nf_px2: got valid=%b data=%h want 1 4c", nf_valid, nf_data);
        end
    endtask

    task automatic test_reset_mid_frame;
        sel_sw = 9'h010;
        tick(8);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        n_checks++;
        if (fs_active !== 4'd5) begin
            n_fail++;
            $display("FAIL rmf_setup: got sel=%0d want 5", fs_active);
        end
        tick(3);
        rst = 1'b1;                            // cycle R
        tick(1);                               // R+1
        rst = 1'b0;
        n_checks++;
        if ({fs_data, fs_valid, fs_active, fs_pending} !== 14'h0) begin
            n_fail++;
            $display("FAIL rmf_reset: got data=%h valid=%b sel=%0d pend=%b want all zero",
                     fs_data, fs_valid, fs_active, fs_pending);
        end
        tick(1);                               // R+2
        n_checks++;
        if (fs_data !== 8'hA5 || fs_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rmf_bypass: got data=%h valid=%b want a5 1", fs_data, fs_valid);
        end
        tick(2);                               // R+4
        frame_start = 1'b1;
        tick(1);                               // R+5
        frame_start = 1'b0;
        n_checks++;
        if (fs_active !== 4'd0) begin
            n_fail++;
            $display("FAIL rmf_early_frame: got sel=%0d want 0", fs_active);
        end
        tick(3);                               // R+8
        n_checks++;
        if (fs_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL rmf_pend: got %b want 1", fs_pending);
        end
        tick(2);                               // R+10
        frame_start = 1'b1;
        tick(1);                               // R+11
        frame_start = 1'b0;
        n_checks++;
        if (fs_active !== 4'd5) begin
            n_fail++;
            $display("FAIL rmf_recommit: got sel=%0d want 5", fs_active);
        end
    endtask

    initial begin
        rst          = 1'b1;
        sel_sw       = '0;
        frame_start  = 1'b0;
        ch_valid     = '1;
        bypass_data  = '0;
        bypass_valid = 1'b0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            ch_data[k*DW +: DW] = 8'(32'h31 + k);
        end

        test_reset();
        test_frame_commit();
        test_bounce();
        test_pending_cancel();
        test_multi_bit();
        test_no_frame_sync();
        test_reset_mid_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
